// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the M-stage data cache.
//   state_t    - controller FSM states
//   idx_width  - index bits for a given number of sets
//   tag_width  - tag bits for a given address width and number of sets
//   byte_merge - byte-lane merge of a store into an existing word
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Widest word the merge helper handles; callers zero-extend to this width.
  localparam int MERGE_MAX_W = 128;

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  // Two low address bits select a byte inside the word and are not part of the tag.
  function automatic int tag_width(input int addr_w, input int sets);
    return addr_w - 2 - $clog2(sets);
  endfunction

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_w,
    input logic [MERGE_MAX_W-1:0]   new_w,
    input logic [MERGE_MAX_W/8-1:0] strb
  );
    logic [MERGE_MAX_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MERGE_MAX_W / 8; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/tag/data storage for a direct-mapped cache.
//   clk, rst      - clock; synchronous active-high reset clears all valid bits
//   rd_idx        - combinational read port index
//   rd_valid/tag/data - contents of line rd_idx
//   wr_en         - write line wr_idx this cycle
//   wr_merge      - 0: fill (valid=1, tag, full data); 1: merge strobed bytes into data only
//   wr_idx/tag/data/strb - write port payload
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int SETS       = 256,
  parameter int IDX_W      = 8,
  parameter int TAG_W      = 22,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_valid,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wr_en,
  input  logic                    wr_merge,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb
);

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  logic [MERGE_MAX_W-1:0]            merged_wide;
  logic [DATA_WIDTH-1:0]             merged;
  logic [MERGE_MAX_W-DATA_WIDTH-1:0] unused_merge_hi;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_comb begin
    merged_wide = byte_merge(MERGE_MAX_W'(data_q[wr_idx]), MERGE_MAX_W'(wr_data),
                             (MERGE_MAX_W/8)'(wr_strb));
  end

  assign merged          = merged_wide[DATA_WIDTH-1:0];
  assign unused_merge_hi = merged_wide[MERGE_MAX_W-1:DATA_WIDTH];

  // Only the valid bits need reset; tag/data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en && !wr_merge) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_merge) begin
        data_q[wr_idx] <= merged;
      end else begin
        tag_q[wr_idx]  <= wr_tag;
        data_q[wr_idx] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/dcache_stall_ctrl.sv
// dcache_stall_ctrl: direct-mapped, write-through, read-allocate M-stage data cache.
//   clk, rst                  - clock; synchronous active-high reset
//   memoryRead_m/Write_m      - load/store in M stage (write wins if both)
//   addr_m, wdata_m, byte_en_m - access address, store data, store strobes
//   rdata_m                   - load data (line on hit in IDLE, fill_buf in RESP, else 0)
//   mem_stall                 - freeze pipeline while a miss/write-through is outstanding
//   mem_req/we/addr/wdata/wstrb, mem_rdata, mem_ready - main-memory port
//   hit_count, miss_count     - saturating read hit/miss counters
//   state_dbg                 - current FSM state
//
// Memory handshake: mem_req is a level request; address, we, wdata and wstrb
// are held stable while mem_req is high. mem_ready is a single-cycle pulse that
// completes the request; mem_req drops the following cycle. mem_ready seen while
// no request is outstanding is ignored.
module dcache_stall_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memoryRead_m,
  input  logic                    memoryWrite_m,
  input  logic [ADDR_WIDTH-1:0]   addr_m,
  input  logic [DATA_WIDTH-1:0]   wdata_m,
  input  logic [DATA_WIDTH/8-1:0] byte_en_m,
  output logic [DATA_WIDTH-1:0]   rdata_m,
  output logic                    mem_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic [CNT_WIDTH-1:0]    hit_count,
  output logic [CNT_WIDTH-1:0]    miss_count,
  output logic [1:0]              state_dbg
);

  localparam int IDX_W = idx_width(SETS);
  localparam int TAG_W = tag_width(ADDR_WIDTH, SETS);

  state_t                state_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic                  resp_rd_q;
  logic [DATA_WIDTH-1:0] fill_buf_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q;
  logic [CNT_WIDTH-1:0]  miss_cnt_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            unused_addr_offset;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  hit;
  logic                  is_wr;
  logic                  is_rd;
  logic                  arr_wr_en;
  logic                  arr_wr_merge;
  logic [DATA_WIDTH-1:0] arr_wr_data;

  assign idx                = addr_m[IDX_W+1:2];
  assign tag                = addr_m[ADDR_WIDTH-1:IDX_W+2];
  assign unused_addr_offset = addr_m[1:0];

  assign is_wr = memoryWrite_m;
  assign is_rd = memoryRead_m && !memoryWrite_m;
  assign hit   = line_valid && (line_tag == tag);

  // The pipeline is frozen during RD_MISS/WR_THRU, so addr_m still names the
  // outstanding access and can be used for both the fill and the write merge.
  assign arr_wr_en    = mem_ready && ((state_q == RD_MISS) || ((state_q == WR_THRU) && hit));
  assign arr_wr_merge = (state_q == WR_THRU);
  assign arr_wr_data  = (state_q == RD_MISS) ? mem_rdata : wdata_m;

  dcache_line_array #(
    .SETS       (SETS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_wr_en),
    .wr_merge (arr_wr_merge),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (arr_wr_data),
    .wr_strb  (byte_en_m)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      resp_rd_q  <= 1'b0;
      fill_buf_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_wr) begin
            state_q   <= WR_THRU;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
          end else if (is_rd) begin
            if (hit) begin
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end else begin
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
              state_q   <= RD_MISS;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
            end
          end
        end
        RD_MISS: begin
          if (mem_ready) begin
            fill_buf_q <= mem_rdata;
            resp_rd_q  <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= RESP;
          end
        end
        WR_THRU: begin
          if (mem_ready) begin
            resp_rd_q <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          // Pipeline advances at the end of RESP; never re-look-up this access.
          resp_rd_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_stall = 1'b0;
    rdata_m   = '0;
    case (state_q)
      IDLE: begin
        mem_stall = is_wr || (is_rd && !hit);
        if (is_rd && hit) rdata_m = line_data;
      end
      RD_MISS, WR_THRU: mem_stall = 1'b1;
      RESP: if (resp_rd_q) rdata_m = fill_buf_q;
      default: mem_stall = 1'b0;
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = {addr_m[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata  = wdata_m;
  assign mem_wstrb  = byte_en_m;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// tb_dcache_stall_ctrl: directed bench for dcache_stall_ctrl with a small
// responder for the memory port. Counters are built 4 bits wide so saturation
// is reachable quickly.
module tb_dcache_stall_ctrl;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SETS = 256;
  localparam int CW   = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          memoryRead_m, memoryWrite_m;
  logic [AW-1:0] addr_m;
  logic [DW-1:0] wdata_m;
  logic [3:0]    byte_en_m;
  logic [DW-1:0] rdata_m;
  logic          mem_stall, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [CW-1:0] hit_count, miss_count;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  dcache_stall_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SETS       (SETS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .memoryRead_m  (memoryRead_m),
    .memoryWrite_m (memoryWrite_m),
    .addr_m        (addr_m),
    .wdata_m       (wdata_m),
    .byte_en_m     (byte_en_m),
    .rdata_m       (rdata_m),
    .mem_stall     (mem_stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives one access from a negedge and plays memory: mem_ready is pulsed on
  // the lat-th cycle that mem_req is seen high. Ends after the first non-stall
  // cycle (IDLE hit or RESP), with the access held through that cycle's edge.
  task automatic run_access(input bit is_wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [3:0] be,
                            input int lat, input logic [DW-1:0] ret,
                            output int stall_cyc, output int req_cyc,
                            output logic [DW-1:0] rd_out);
    bit done;
    bit first;
    done      = 1'b0;
    first     = 1'b1;
    stall_cyc = 0;
    req_cyc   = 0;
    rd_out    = '0;
    @(negedge clk);
    memoryRead_m  = !is_wr;
    memoryWrite_m = is_wr;
    addr_m        = addr;
    wdata_m       = wdata;
    byte_en_m     = be;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (mem_req) begin
        req_cyc++;
        if (first) begin
          check("mem_addr", mem_addr, {addr[AW-1:2], 2'b00});
          check("mem_we", mem_we, is_wr);
          if (is_wr) begin
            check("mem_wstrb", mem_wstrb, be);
            check("mem_wdata", mem_wdata, wdata);
          end
          first = 1'b0;
        end
        if (req_cyc == lat) begin
          mem_ready = 1'b1;
          mem_rdata = ret;
        end
      end
      if (!mem_stall) begin
        rd_out = rdata_m;
        done   = 1'b1;
      end else begin
        stall_cyc++;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
    memoryRead_m  = 1'b0;
    memoryWrite_m = 1'b0;
    if (!done) check("access_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_load(input string tag, input logic [AW-1:0] addr, input int lat,
                         input logic [DW-1:0] ret, input logic [DW-1:0] exp_data,
                         input int exp_stall);
    int            st, rq;
    logic [DW-1:0] rd;
    exp_q.push_back(exp_data);
    run_access(1'b0, addr, '0, 4'h0, lat, ret, st, rq, rd);
    check({tag, "_rdata"}, rd, exp_q.pop_front());
    check({tag, "_stall"}, 64'(st), 64'(exp_stall));
    check({tag, "_reqcyc"}, 64'(rq), (exp_stall == 0) ? 64'd0 : 64'(lat));
  endtask

  task automatic do_store(input string tag, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [3:0] be, input int lat,
                          input int exp_stall);
    int            st, rq;
    logic [DW-1:0] rd;
    run_access(1'b1, addr, wdata, be, lat, '0, st, rq, rd);
    check({tag, "_stall"}, 64'(st), 64'(exp_stall));
    check({tag, "_reqcyc"}, 64'(rq), 64'(lat));
    check({tag, "_rdata"}, rd, 64'd0);
  endtask

  task automatic check_counters(input string tag, input int hits, input int misses);
    check({tag, "_hits"}, hit_count, 64'(hits));
    check({tag, "_misses"}, miss_count, 64'(misses));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    memoryRead_m  = 1'b0;
    memoryWrite_m = 1'b0;
    addr_m        = '0;
    wdata_m       = '0;
    byte_en_m     = '0;
    mem_rdata     = '0;
    mem_ready     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", state_dbg, 64'd0);
    check("rst_mem_req", mem_req, 64'd0);
    check("rst_mem_we", mem_we, 64'd0);
    check("rst_stall", mem_stall, 64'd0);
    check("rst_rdata", rdata_m, 64'd0);
    check_counters("rst", 0, 0);

    // Cold miss, 3-cycle memory -> 4 stall cycles, fill shown in RESP.
    do_load("ld0", 32'h100, 3, 32'hDEADBEEF, 32'hDEADBEEF, 4);
    check_counters("ld0", 0, 1);
    // Same line now hits at zero latency.
    do_load("ld1", 32'h100, 1, 32'h0, 32'hDEADBEEF, 0);
    check_counters("ld1", 1, 1);

    // Store hit: low byte merged into the line.
    do_store("st0", 32'h100, 32'h000000AA, 4'b0001, 2, 3);
    do_load("ld2", 32'h100, 1, 32'h0, 32'hDEADBEAA, 0);
    check_counters("ld2", 2, 1);

    // Store miss: write-through only, no allocate.
    do_store("st1", 32'h2000, 32'h12345678, 4'b1111, 1, 2);
    do_load("ld3", 32'h2000, 2, 32'h55667788, 32'h55667788, 3);
    check_counters("ld3", 2, 2);

    // Aliasing: same index, different tag evicts.
    do_load("ld4", 32'h100, 1, 32'h0, 32'hDEADBEAA, 0);
    do_load("ld5", 32'h100 + 4 * SETS, 1, 32'h0BADF00D, 32'h0BADF00D, 2);
    do_load("ld6", 32'h100, 1, 32'hCAFEF00D, 32'hCAFEF00D, 2);
    // Byte offset is ignored for lookup.
    do_load("ld7", 32'h102, 1, 32'h0, 32'hCAFEF00D, 0);
    check_counters("ld7", 4, 4);

    // Reset during RD_MISS, then a stray mem_ready in IDLE.
    @(negedge clk);
    memoryRead_m = 1'b1;
    addr_m       = 32'h100 + 4 * SETS;
    @(negedge clk);
    #1;
    check("mid_state_rdmiss", state_dbg, 64'd1);
    check("mid_req", mem_req, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    memoryRead_m = 1'b0;
    #1;
    check("mrst_state", state_dbg, 64'd0);
    check("mrst_req", mem_req, 64'd0);
    check("mrst_stall", mem_stall, 64'd0);
    check_counters("mrst", 0, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    check("stray_state", state_dbg, 64'd0);
    check("stray_req", mem_req, 64'd0);
    check("stray_rdata", rdata_m, 64'd0);
    // Lines valid before reset must miss now.
    do_load("ld8", 32'h100, 1, 32'h11112222, 32'h11112222, 2);
    do_load("ld9", 32'h2000, 1, 32'h33334444, 32'h33334444, 2);
    check_counters("ld9", 0, 2);

    // Hit counter saturates at 4'hF.
    for (int k = 0; k < 20; k++) begin
      do_load("sat", 32'h2000, 1, 32'h0, 32'h33334444, 0);
    end
    check_counters("sat", 15, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_stall_ctrl.md
Name: dcache_stall_ctrl

Overview:
Direct-mapped, write-through, read-allocate data cache in the Memory stage. It sits between the M-stage load/store signals and the main-memory port. It produces mem_stall, which the hazard unit consumes to freeze the pipeline and flush Execute while a miss or write-through is outstanding. It also keeps hit/miss counters for performance bring-up.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width; one word per line
SETS, 256, number of lines; power of two, minimum 2
CNT_WIDTH, 32, width of the hit/miss counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
memoryRead_m  in  1  load in M stage
memoryWrite_m  in  1  store in M stage
addr_m  in  ADDR_WIDTH  byte address from ALU result
wdata_m  in  DATA_WIDTH  store data, already lane-aligned
byte_en_m  in  DATA_WIDTH/8  store byte strobes
rdata_m  out  DATA_WIDTH  load data to writeback mux
mem_stall  out  1  to hazard unit; request outstanding
mem_req  out  1  main-memory request, held until mem_ready
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  word-aligned request address
mem_wdata  out  DATA_WIDTH  write data
mem_wstrb  out  DATA_WIDTH/8  write strobes
mem_rdata  in  DATA_WIDTH  read return data
mem_ready  in  1  one-cycle completion pulse
hit_count  out  CNT_WIDTH  saturating count of read hits
miss_count  out  CNT_WIDTH  saturating count of read misses

Behaviour:
- Address split: offset [1:0] is ignored for lookup. Index is [IDX+1:2] with IDX = log2(SETS). Tag is the remaining upper bits.
- Storage: per line, a valid bit, a tag and a data word. Valid bits are in flops.
- Reset: in the same cycle rst is high, all valid bits clear, FSM goes to IDLE, counters clear, and fill_buf clears.
  - Outputs after reset: mem_req=0, mem_we=0, mem_stall=0, rdata_m=0.
  - Reset mid-transaction abandons the request. A stray mem_ready while in IDLE is ignored.
- FSM states: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE, read hit:
  - rdata_m is the line data, combinational, zero latency.
  - mem_stall=0.
  - hit_count increments.
- IDLE, read miss:
  - mem_stall=1 combinationally in the same cycle.
  - Next state is RD_MISS.
  - miss_count increments once.
- IDLE, write:
  - mem_stall=1 combinationally in the same cycle.
  - Next state is WR_THRU.
  - A write is always a stall, whether it hits or misses.
- Read and write asserted together is illegal. The write takes priority.
- RD_MISS:
  - mem_req=1 and mem_we=0, with mem_addr = {addr_m[ADDR_WIDTH-1:2], 2'b00}. These are held stable until mem_ready.
  - mem_stall=1.
  - On mem_ready: capture mem_rdata into fill_buf, write the line (valid=1, tag, data), go to RESP. mem_req drops the cycle after mem_ready.
- WR_THRU:
  - mem_req=1 and mem_we=1, driving mem_wdata=wdata_m and mem_wstrb=byte_en_m.
  - mem_stall=1.
  - On mem_ready: if the tag hits a valid line, merge the strobed bytes into the line; otherwise leave the cache untouched (no write-allocate). Go to RESP.
- RESP:
  - Lasts exactly one cycle, with mem_stall=0 and mem_req=0.
  - For a read, rdata_m = fill_buf.
  - The pipeline advances at the end of this cycle. RESP always returns to IDLE and never re-looks-up the access.
- Latency:
  - Read hit: 0 stall cycles.
  - Miss or write: N+1 stall cycles, where N is the number of cycles from mem_req asserting to mem_ready inclusive; the +1 is the IDLE lookup cycle. RESP is not a stall cycle.
- Counters saturate at all-ones and do not wrap.
- Any read miss on a valid line evicts it unconditionally. Write-through means there is no dirty state.

Decomposition:
- Shared package dcache_pkg holds:
  - the state enum (IDLE, RD_MISS, WR_THRU, RESP);
  - the IDX and TAG width functions of the parameters;
  - the byte-merge function (old word, new word, strobes -> merged word).
- One natural sub-module, dcache_line_array: valid/tag/data storage with one combinational read port and one synchronous write port (full-word write or strobe merge), with reset clearing the valid bits.

Test Plan:
- Reset, then load 0x100 with mem_ready 3 cycles after mem_req, returning 0xDEADBEEF -> mem_stall high for 4 cycles; RESP shows rdata_m=0xDEADBEEF; miss_count=1.
- Load 0x100 again -> rdata_m=0xDEADBEEF in the same cycle; mem_stall=0; hit_count=1; mem_req stays 0.
- Store 0x100, wdata=0x000000AA, byte_en=0001 -> mem_req with we=1, wstrb=0001; then a load of 0x100 hits with 0xDEADBEAA.
- Store a miss at 0x2000 -> write-through issued; a following load of 0x2000 misses (no allocate); miss_count increments.
- Aliasing: load 0x100, then 0x100+4*SETS -> second load misses and evicts; reloading 0x100 misses again.
- Assert rst during RD_MISS, then pulse mem_ready after reset -> state stays IDLE; mem_req=0; all lines invalid; counters 0.
